seg_to_bcd_reader: RTL



---
 rtl/seg_pkg.sv | 36 +++
 rtl/seg_to_bcd_reader_if.sv | 32 +++
 rtl/seg_pattern_decode.sv | 38 +++
 rtl/seg_to_bcd_reader.sv | 130 +++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared definitions for the 7-segment encode/decode pair.
//   - segment bit indices on the 8-bit bus (a..g, dp)
//   - the ten digit patterns, the blank pattern and the error BCD code
//   - state encoding for seg_to_bcd_reader
package seg_pkg;

  localparam int unsigned SEG_A  = 0;
  localparam int unsigned SEG_B  = 1;
  localparam int unsigned SEG_C  = 2;
  localparam int unsigned SEG_D  = 3;
  localparam int unsigned SEG_E  = 4;
  localparam int unsigned SEG_F  = 5;
  localparam int unsigned SEG_G  = 6;
  localparam int unsigned SEG_DP = 7;

  localparam logic [6:0] PAT_0     = 7'h3F;
  localparam logic [6:0] PAT_1     = 7'h06;
  localparam logic [6:0] PAT_2     = 7'h5B;
  localparam logic [6:0] PAT_3     = 7'h4F;
  localparam logic [6:0] PAT_4     = 7'h66;
  localparam logic [6:0] PAT_5     = 7'h6D;
  localparam logic [6:0] PAT_6     = 7'h7D;
  localparam logic [6:0] PAT_7     = 7'h07;
  localparam logic [6:0] PAT_8     = 7'h7F;
  localparam logic [6:0] PAT_9     = 7'h6F;
  localparam logic [6:0] PAT_BLANK = 7'h00;

  localparam logic [3:0] BCD_ERR = 4'hF;

  typedef enum logic [1:0] {
    StIdle,
    StSettle,
    StEmit
  } state_e;

endpackage

// File: rtl/seg_to_bcd_reader_if.sv
// Segment-bus input plus decoded-result valid/ready channel.
//   master : the reader (samples inbus/ready, drives the result)
//   slave  : the display side / consumer
interface seg_to_bcd_reader_if;
  logic [7:0] inbus;
  logic [3:0] outbus;
  logic       dp;
  logic       blank;
  logic       err;
  logic       valid;
  logic       ready;

  modport master (
    input  inbus,
    input  ready,
    output outbus,
    output dp,
    output blank,
    output err,
    output valid
  );

  modport slave (
    output inbus,
    output ready,
    input  outbus,
    input  dp,
    input  blank,
    input  err,
    input  valid
  );
endinterface

// File: rtl/seg_pattern_decode.sv
// Combinational 7-segment pattern to BCD lookup.
//   pat_i   : segments a..g (bit0 = a)
//   digit_o : BCD digit, 0 for blank, BCD_ERR for illegal patterns
//   blank_o : all segments off
//   err_o   : neither a digit nor blank
module seg_pattern_decode
  import seg_pkg::*;
(
  input  logic [6:0] pat_i,
  output logic [3:0] digit_o,
  output logic       blank_o,
  output logic       err_o
);

  always_comb begin
    digit_o = 4'h0;
    blank_o = 1'b0;
    err_o   = 1'b0;
    case (pat_i)
      PAT_0:     digit_o = 4'd0;
      PAT_1:     digit_o = 4'd1;
      PAT_2:     digit_o = 4'd2;
      PAT_3:     digit_o = 4'd3;
      PAT_4:     digit_o = 4'd4;
      PAT_5:     digit_o = 4'd5;
      PAT_6:     digit_o = 4'd6;
      PAT_7:     digit_o = 4'd7;
      PAT_8:     digit_o = 4'd8;
      PAT_9:     digit_o = 4'd9;
      PAT_BLANK: blank_o = 1'b1;
      default: begin
        digit_o = BCD_ERR;
        err_o   = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/seg_to_bcd_reader.sv
// Debounced 7-segment bus reader.
// Registers the segment bus, waits for a pattern to hold for STABLE_CYCLES
// samples, decodes it and offers one result per distinct stable pattern on a
// valid/ready handshake.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : inbus/ready in, outbus/dp/blank/err/valid out
module seg_to_bcd_reader
  import seg_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 4,
  parameter int unsigned CNT_W         = 8
) (
  input logic                 clk,
  input logic                 rst_n,
  seg_to_bcd_reader_if.master bus
);

  localparam logic [CNT_W-1:0] StableCnt = CNT_W'(STABLE_CYCLES);

  state_e           state_q, state_d;
  logic [7:0]       sample_q, sample_d;
  logic [7:0]       prev_q, prev_d;
  logic [7:0]       last_pat_q, last_pat_d;
  logic             have_last_q, have_last_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       outbus_q, outbus_d;
  logic             dp_q, dp_d;
  logic             blank_q, blank_d;
  logic             err_q, err_d;
  logic             valid_q, valid_d;

  logic [3:0]       dec_digit;
  logic             dec_blank;
  logic             dec_err;
  logic [CNT_W-1:0] cnt_inc;

  seg_pattern_decode u_decode (
    .pat_i   (sample_q[6:0]),
    .digit_o (dec_digit),
    .blank_o (dec_blank),
    .err_o   (dec_err)
  );

  // Saturating increment: the count never wraps past STABLE_CYCLES.
  assign cnt_inc = (cnt_q >= StableCnt) ? cnt_q : cnt_q + CNT_W'(1);

  always_comb begin
    state_d     = state_q;
    sample_d    = bus.inbus;
    prev_d      = sample_q;
    last_pat_d  = last_pat_q;
    have_last_d = have_last_q;
    cnt_d       = cnt_q;
    outbus_d    = outbus_q;
    dp_d        = dp_q;
    blank_d     = blank_q;
    err_d       = err_q;
    valid_d     = valid_q;

    unique case (state_q)
      StIdle: begin
        if (!have_last_q || (sample_q != last_pat_q)) begin
          state_d = StSettle;
          cnt_d   = CNT_W'(1);
        end
      end
      StSettle: begin
        if (sample_q == prev_q) begin
          cnt_d = cnt_inc;
          if (cnt_inc >= StableCnt) begin
            outbus_d    = dec_digit;
            dp_d        = sample_q[SEG_DP];
            blank_d     = dec_blank;
            err_d       = dec_err;
            last_pat_d  = sample_q;
            have_last_d = 1'b1;
            valid_d     = 1'b1;
            state_d     = StEmit;
          end
        end else begin
          cnt_d = CNT_W'(1);
        end
      end
      StEmit: begin
        // Bus activity is ignored here; IDLE re-compares against last_pat.
        if (bus.ready) begin
          valid_d = 1'b0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      sample_q    <= 8'h00;
      prev_q      <= 8'h00;
      last_pat_q  <= 8'h00;
      have_last_q <= 1'b0;
      cnt_q       <= '0;
      outbus_q    <= 4'h0;
      dp_q        <= 1'b0;
      blank_q     <= 1'b0;
      err_q       <= 1'b0;
      valid_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      sample_q    <= sample_d;
      prev_q      <= prev_d;
      last_pat_q  <= last_pat_d;
      have_last_q <= have_last_d;
      cnt_q       <= cnt_d;
      outbus_q    <= outbus_d;
      dp_q        <= dp_d;
      blank_q     <= blank_d;
      err_q       <= err_d;
      valid_q     <= valid_d;
    end
  end

  assign bus.outbus = outbus_q;
  assign bus.dp     = dp_q;
  assign bus.blank  = blank_q;
  assign bus.err    = err_q;
  assign bus.valid  = valid_q;

endmodule
